// File: rtl/mod_mult_pipe.sv
// Pipelined Barrett modular multiplier, out = (a*b) mod q, one result/cycle.
// Optional macro MOD_MULT_RANGE_CHECK_EN adds out_range_err (operand >= q).
module mod_mult_pipe #(
    parameter int                WIDTH   = 64,
    parameter int                K       = 64,
    parameter int                TAG_W   = 8,
    parameter logic [WIDTH-1:0]  Q_INIT  = 64'hFFFF_FFFF_0000_0001,
    parameter logic [K:0]        MU_INIT = 65'h1_0000_0000_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_q,
    input  logic [K:0]       cfg_mu,
`ifdef MOD_MULT_RANGE_CHECK_EN
    output logic             out_range_err,
`endif
    output logic             cfg_err
);

    logic [K-1:0]     r_q;
    logic [K:0]       r_mu;

    logic             r_s1_v;
    logic [2*K-1:0]   r_s1_z;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_v;
    logic [K:0]       r_s2_t;
    logic [K+1:0]     r_s2_zlo;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s3_v;
    logic [K+1:0]     r_s3_r;
    logic [TAG_W-1:0] r_s3_tag;
    logic             r_s4_v;
    logic [WIDTH-1:0] r_s4_data;
    logic [TAG_W-1:0] r_s4_tag;

    logic             w_stall;
    logic             w_cfg_fire;
    logic             w_cfg_ok;
    logic             w_acc;
    logic             w_en1;
    logic             w_en2;
    logic             w_en3;
    logic             w_en4;
    logic [2*K-1:0]   w_z;
    logic [K:0]       w_zs;
    logic [K:0]       w_t;
    logic [K+1:0]     w_tq;
    logic [K+1:0]     w_r0;
    logic [K+1:0]     w_qx;
    logic [K+1:0]     w_r1;
    logic [K+1:0]     w_r2;

    // A stage may load when it is empty or its successor is moving,
    // so bubbles are squeezed out while the output is held.
    assign w_stall    = r_s4_v & ~out_ready;
    assign w_en4      = ~r_s4_v | out_ready;
    assign w_en3      = ~r_s3_v | w_en4;
    assign w_en2      = ~r_s2_v | w_en3;
    assign w_en1      = ~r_s1_v | w_en2;

    assign cfg_ready  = ~(r_s1_v | r_s2_v | r_s3_v | r_s4_v) & ~in_valid;
    assign w_cfg_fire = cfg_valid & cfg_ready;
    assign w_cfg_ok   = cfg_q[K-1] & ((cfg_q >> K) == '0);
    assign cfg_err    = w_cfg_fire & ~w_cfg_ok & ~rst;
    assign in_ready   = ~w_stall & ~w_cfg_fire;
    assign w_acc      = in_valid & in_ready;

    assign w_z  = (2*K)'(in_a[K-1:0]) * (2*K)'(in_b[K-1:0]);
    assign w_zs = r_s1_z[2*K-1:K-1];
    assign w_t  = (K+1)'(((2*K+2)'(w_zs) * (2*K+2)'(r_mu)) >> (K+1));
    assign w_tq = (K+2)'(r_s2_t) * (K+2)'(r_q);
    assign w_r0 = r_s2_zlo - w_tq;
    assign w_qx = {2'b00, r_q};
    assign w_r1 = (r_s3_r >= w_qx) ? (r_s3_r - w_qx) : r_s3_r;
    assign w_r2 = (w_r1 >= w_qx) ? (w_r1 - w_qx) : w_r1;

    assign out_valid = r_s4_v;
    assign out_data  = r_s4_data;
    assign out_tag   = r_s4_tag;

    // Modulus pair: only a legal value is loaded, and only into an empty pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= Q_INIT[K-1:0];
            r_mu <= MU_INIT;
        end else if (w_cfg_fire & w_cfg_ok) begin
            r_q  <= cfg_q[K-1:0];
            r_mu <= cfg_mu;
        end
    end

    // Stage valid bits advance under the per-stage enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s3_v <= 1'b0;
            r_s4_v <= 1'b0;
        end else begin
            if (w_en1) r_s1_v <= w_acc;
            if (w_en2) r_s2_v <= r_s1_v;
            if (w_en3) r_s3_v <= r_s2_v;
            if (w_en4) r_s4_v <= r_s3_v;
        end
    end

    // Datapath registers load only when a valid item moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_z    <= '0;
            r_s1_tag  <= '0;
            r_s2_t    <= '0;
            r_s2_zlo  <= '0;
            r_s2_tag  <= '0;
            r_s3_r    <= '0;
            r_s3_tag  <= '0;
            r_s4_data <= '0;
            r_s4_tag  <= '0;
        end else begin
            if (w_en1 & w_acc) begin
                r_s1_z   <= w_z;
                r_s1_tag <= in_tag;
            end
            if (w_en2 & r_s1_v) begin
                r_s2_t   <= w_t;
                r_s2_zlo <= r_s1_z[K+1:0];
                r_s2_tag <= r_s1_tag;
            end
            if (w_en3 & r_s2_v) begin
                r_s3_r   <= w_r0;
                r_s3_tag <= r_s2_tag;
            end
            if (w_en4 & r_s3_v) begin
                r_s4_data <= WIDTH'(w_r2);
                r_s4_tag  <= r_s3_tag;
            end
        end
    end

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic r_s1_rg;
    logic r_s2_rg;
    logic r_s3_rg;
    logic r_s4_rg;
    logic w_rg;

    assign w_rg = (in_a >= WIDTH'(r_q)) | (in_b >= WIDTH'(r_q));
    assign out_range_err = r_s4_rg;

    // Range flag rides alongside its transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_rg <= 1'b0;
            r_s2_rg <= 1'b0;
            r_s3_rg <= 1'b0;
            r_s4_rg <= 1'b0;
        end else begin
            if (w_en1 & w_acc)  r_s1_rg <= w_rg;
            if (w_en2 & r_s1_v) r_s2_rg <= r_s1_rg;
            if (w_en3 & r_s2_v) r_s3_rg <= r_s2_rg;
            if (w_en4 & r_s3_v) r_s4_rg <= r_s3_rg;
        end
    end
`endif

endmodule

// File: tb/tb_mod_mult_pipe.sv
// Scoreboard bench for mod_mult_pipe.
// Expected results are queued on accept and compared on output.
module tb_mod_mult_pipe;

    localparam logic [63:0] GOLD    = 64'hFFFF_FFFF_0000_0001;
    localparam logic [64:0] MU_GOLD = 65'h1_0000_0000_FFFF_FFFF;
    localparam logic [63:0] Q2      = 64'hFFFF_FFFF_FFFF_FFC5;
    localparam logic [64:0] MU_Q2   = 65'h1_0000_0000_0000_003B;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_tag;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [63:0] cfg_q;
    logic [64:0] cfg_mu;
    logic        cfg_err;
`ifdef MOD_MULT_RANGE_CHECK_EN
    logic        out_range_err;
`endif

    mod_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_q     (cfg_q),
        .cfg_mu    (cfg_mu),
`ifdef MOD_MULT_RANGE_CHECK_EN
        .out_range_err (out_range_err),
`endif
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  t;
        bit          cd;
        bit          rg;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_head;
    exp_t        e_new;
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_in    = 0;
    int          n_out   = 0;
    int          cyc     = 0;
    logic [63:0] m_q     = GOLD;
    bit          mon_en  = 1'b0;
    bit          rdy_rand = 1'b0;
    logic        rdy_fix = 1'b1;
    bit          cur_cd  = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mmul(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] q);
        logic [127:0] z;
        z = {64'd0, a} * {64'd0, b};
        return 64'(z % {64'd0, q});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("orphan_out", 64'(out_valid), 64'd0);
                end else begin
                    e_head = sb[0];
                    if (e_head.cd) chk("data", out_data, e_head.d);
                    chk("tag", 64'(out_tag), 64'(e_head.t));
`ifdef MOD_MULT_RANGE_CHECK_EN
                    chk("rng", 64'(out_range_err), 64'(e_head.rg));
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e_new.d  = mmul(in_a, in_b, m_q);
                e_new.t  = in_tag;
                e_new.cd = cur_cd;
                e_new.rg = (in_a >= m_q) || (in_b >= m_q);
                sb.push_back(e_new);
                n_in++;
            end
            if (cfg_valid && cfg_ready && cfg_q[63]) m_q = cfg_q;
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int cnt);
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < cnt; i++) begin
            a = {$urandom, $urandom} % m_q;
            b = {$urandom, $urandom} % m_q;
            send(a, b, 8'(i));
        end
    endtask

    initial begin
        int lat;
        int nw;
        int t0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        cfg_valid = 1'b0;
        cfg_q = '0;
        cfg_mu = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_od", out_data, 64'd0);
        chk("rst_ot", 64'(out_tag), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);
        chk("rst_irdy", 64'(in_ready), 64'd1);
        chk("rst_crdy", 64'(cfg_ready), 64'd1);
`ifdef MOD_MULT_RANGE_CHECK_EN
        chk("rst_rng", 64'(out_range_err), 64'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        in_valid = 1'b1;
        in_a = GOLD - 64'd1;
        in_b = GOLD - 64'd1;
        in_tag = 8'h11;
        @(negedge clk);
        chk("acc_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("qm1_sq", out_data, 64'd1);
        drain();

        send(64'h1_0000_0000, 64'h1_0000_0000, 8'h22);
        wait_out();
        chk("p32_sq", out_data, 64'h0000_0000_FFFF_FFFF);
        drain();

        t0 = cyc;
        rand_ops(1000);
        chk("thruput", 64'(cyc - t0), 64'd1000);
        drain();

        rdy_rand = 1'b1;
        rand_ops(500);
        drain();
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(64'd3, 64'd7, 8'h31);
        send(GOLD - 64'd2, 64'd9, 8'h32);
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 8'h33);
        cfg_valid = 1'b1;
        cfg_q = Q2;
        cfg_mu = MU_Q2;
        nw = 0;
        @(negedge clk);
        chk("cfg_busy", 64'(cfg_ready), 64'd0);
        while (!cfg_ready && nw < 50) begin
            nw++;
            @(negedge clk);
        end
        chk("cfg_wait", 64'(nw), 64'd4);
        chk("cfg_ok_err", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        send(64'h8000_0000_0000_0000, 64'd2, 8'h40);
        wait_out();
        chk("q2_59", out_data, 64'd59);
        drain();

        cfg_valid = 1'b1;
        cfg_q = 64'h7FFF_FFFF_FFFF_FFFF;
        cfg_mu = MU_GOLD;
        @(negedge clk);
        chk("bad_cfg_err", 64'(cfg_err), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
        send(m_q - 64'd1, m_q - 64'd1, 8'h50);
        wait_out();
        chk("q_kept_sq", out_data, 64'd1);
        drain();
        send(64'h8000_0000_0000_0000, 64'd2, 8'h51);
        wait_out();
        chk("q_kept_59", out_data, 64'd59);
        drain();

        in_valid = 1'b1;
        in_a = 64'd3;
        in_b = 64'd5;
        in_tag = 8'h60;
        cfg_valid = 1'b1;
        cfg_q = GOLD;
        cfg_mu = MU_GOLD;
        @(negedge clk);
        chk("both_irdy", 64'(in_ready), 64'd1);
        chk("both_crdy", 64'(cfg_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        nw = 0;
        @(negedge clk);
        while (!cfg_ready && nw < 50) begin
            nw++;
            @(negedge clk);
        end
        chk("both_load", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        send(64'h1_0000_0000, 64'h1_0000_0000, 8'h61);
        wait_out();
        chk("gold_back", out_data, 64'h0000_0000_FFFF_FFFF);
        drain();
        rand_ops(40);
        drain();

        rdy_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(64'd11, 64'd13, 8'h71);
        send(64'd17, 64'd19, 8'h72);
        send(64'd23, 64'd29, 8'h73);
        send(64'd31, 64'd37, 8'h74);
        chk("full_ov", 64'(out_valid), 64'd1);
        chk("full_stall", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        n_in = n_in - sb.size();
        sb.delete();
        rst = 1'b0;
        rdy_fix = 1'b1;
        @(negedge clk);
        chk("mid_rst_crdy", 64'(cfg_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        send(GOLD - 64'd1, GOLD - 64'd1, 8'h75);
        wait_out();
        chk("post_rst", out_data, 64'd1);
        drain();

`ifdef MOD_MULT_RANGE_CHECK_EN
        cur_cd = 1'b0;
        send(m_q, 64'd5, 8'h80);
        cur_cd = 1'b1;
        wait_out();
        chk("rng_hi", 64'(out_range_err), 64'd1);
        drain();
        send(64'd5, 64'd7, 8'h81);
        wait_out();
        chk("rng_lo", 64'(out_range_err), 64'd0);
        drain();
`endif

        repeat (5) @(posedge clk);
        chk("count", 64'(n_out), 64'(n_in));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
